// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: opcode codes, latched-op record and decode helpers for the mul/div unit
package muldiv_seq_pkg;

    localparam logic [4:0] ALUOP_MULT  = 5'd24;
    localparam logic [4:0] ALUOP_MULTU = 5'd25;
    localparam logic [4:0] ALUOP_DIV   = 5'd26;
    localparam logic [4:0] ALUOP_DIVU  = 5'd27;

    typedef struct packed {
        logic div;
        logic s0;
        logic s1;
    } op_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU};
    endfunction

    function automatic logic is_signed(input logic [4:0] op);
        return op == ALUOP_MULT || op == ALUOP_DIV;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op == ALUOP_DIV || op == ALUOP_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue, MTHI/MTLO and result signals between the core controller and the mul/div unit
interface muldiv_seq_if #(parameter int WIDTH = 32);

    logic             start_i;
    logic [4:0]       aluop_i;
    logic [WIDTH-1:0] src0_i;
    logic [WIDTH-1:0] src1_i;
    logic             wr_hi_i;
    logic             wr_lo_i;
    logic [WIDTH-1:0] wdata_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, aluop_i, src0_i, src1_i, wr_hi_i, wr_lo_i, wdata_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, aluop_i, src0_i, src1_i, wr_hi_i, wr_lo_i, wdata_i,
        output busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_seq_step: one shift-add multiply or restoring divide iteration on the 2*WIDTH accumulator
module muldiv_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_sub;
    logic             w_nb;

    // mul: add multiplicand to upper half when the multiplier LSB is set, then shift right with carry;
    // div: shift remainder left, subtract divisor when it fits, shift in the quotient bit
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_trial = i_acc[2*WIDTH-1:WIDTH-1];
        w_nb    = w_trial >= {1'b0, i_opnd};
        w_sub   = w_trial[WIDTH-1:0] - i_opnd;
        o_acc   = i_div ? {w_nb ? w_sub : w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], w_nb}
                        : {w_sum, i_acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 1-bit-per-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO pair
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_a0;
    logic [WIDTH-1:0]   w_a1;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    op_t                r_op;
    op_t                w_op;
    logic               w_go;
    logic               w_last;

    assign w_go   = r_state == IDLE && bus.start_i && is_muldiv(bus.aluop_i);
    assign w_op   = '{div: is_div(bus.aluop_i),
                      s0:  is_signed(bus.aluop_i) & bus.src0_i[WIDTH-1],
                      s1:  is_signed(bus.aluop_i) & bus.src1_i[WIDTH-1]};
    assign w_a0   = w_op.s0 ? -bus.src0_i : bus.src0_i;
    assign w_a1   = w_op.s1 ? -bus.src1_i : bus.src1_i;
    assign w_last = r_cnt == CNT_W'(WIDTH - 1);
    assign w_prod = (r_op.s0 ^ r_op.s1) ? -r_acc : r_acc;
    assign w_q    = (r_op.s0 ^ r_op.s1) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r    = r_op.s0 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign bus.busy_o = r_state != IDLE;
    assign bus.done_o = r_state == DONE;
    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;

    muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_op.div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_step)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state: accept in IDLE, iterate WIDTH times, one fix-up cycle, one done cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? RUN : IDLE;
            RUN:     w_next = w_last ? FIX : RUN;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // operand latch, iteration, signed fix-up into HI/LO, and MTHI/MTLO while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_go) begin
                r_op   <= w_op;
                r_cnt  <= '0;
                r_acc  <= {{WIDTH{1'b0}}, w_op.div ? w_a0 : w_a1};
                r_opnd <= w_op.div ? w_a1 : w_a0;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == FIX) begin
                r_hi <= r_op.div ? w_r : w_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_op.div ? w_q : w_prod[WIDTH-1:0];
            end else if (r_state == IDLE && !w_go) begin
                if (bus.wr_hi_i) r_hi <= bus.wdata_i;
                if (bus.wr_lo_i) r_lo <= bus.wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized self-check of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    int          n;

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == ALUOP_MULTU) return ua * ub;
        if (op == ALUOP_MULT)  return 64'(sa * sb);
        if (op == ALUOP_DIVU)  return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
        if (b == 0) return {a, a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // reference: an accepted op shows its result and a done pulse in the 34th cycle after acceptance
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left == 0) begin
            if (bus.start_i && bus.aluop_i inside {ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU}) begin
                m_res  <= ref_op(bus.aluop_i, bus.src0_i, bus.src1_i);
                m_left <= 34;
            end else begin
                if (bus.wr_hi_i) m_hi <= bus.wdata_i;
                if (bus.wr_lo_i) m_lo <= bus.wdata_i;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) {m_hi, m_lo} <= m_res;
        end
    end

    // cycle-by-cycle comparison against the reference
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy_o), 64'(m_left != 0));
            chk("done", 64'(bus.done_o), 64'(m_left == 1));
            chk("hi", 64'(bus.hi_o), 64'(m_hi));
            chk("lo", 64'(bus.lo_o), 64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.aluop_i = op;
        bus.src0_i  = a;
        bus.src1_i  = b;
        tick();
        bus.start_i = 1'b0;
        bus.src0_i  = $urandom;
        bus.src1_i  = $urandom;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (!bus.done_o && cnt < 40);
        tick();
    endtask

    task automatic run(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        issue(op, a, b);
        wait_done(c);
        chk({nm, "_lat"}, 64'(c), 64'd34);
        chk({nm, "_hi"}, 64'(bus.hi_o), 64'(ehi));
        chk({nm, "_lo"}, 64'(bus.lo_o), 64'(elo));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] codes [4] = '{ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU};
        bus.start_i = 1'b0;
        bus.aluop_i = '0;
        bus.src0_i  = '0;
        bus.src1_i  = '0;
        bus.wr_hi_i = 1'b0;
        bus.wr_lo_i = 1'b0;
        bus.wdata_i = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_hi", 64'(bus.hi_o), 64'd0);
        chk("rst_lo", 64'(bus.lo_o), 64'd0);

        chk("ref_multu", ref_op(ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_mult", ref_op(ALUOP_MULT, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ref_div", ref_op(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_divovf", ref_op(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("ref_div0", ref_op(ALUOP_DIV, 32'hFFFF_FFFB, 32'd0), 64'hFFFF_FFFB_0000_0001);

        run("multu", ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult", ALUOP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", ALUOP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu0", ALUOP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run("div0n", ALUOP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001);
        run("div0p", ALUOP_DIV, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        run("divovf", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run("multovf", ALUOP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);

        issue(ALUOP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        issue(ALUOP_MULTU, 32'd3, 32'd3);
        wait_done(n);
        chk("ign_lat", 64'(n), 64'd24);
        chk("ign_hi", 64'(bus.hi_o), 64'd2);
        chk("ign_lo", 64'(bus.lo_o), 64'd14);

        bus.wr_hi_i = 1'b1;
        bus.wdata_i = 32'h1234_5678;
        tick();
        bus.wr_hi_i = 1'b0;
        chk("mthi", 64'(bus.hi_o), 64'h1234_5678);
        issue(ALUOP_MULTU, 32'd6, 32'd7);
        bus.wr_lo_i = 1'b1;
        bus.wdata_i = 32'hDEAD_BEEF;
        tick();
        bus.wr_lo_i = 1'b0;
        chk("mtlo_busy", 64'(bus.lo_o), 64'd14);
        wait_done(n);
        chk("mtlo_busy_lat", 64'(n), 64'd33);
        chk("mtlo_busy_res", 64'(bus.lo_o), 64'd42);
        bus.wr_lo_i = 1'b1;
        bus.wdata_i = 32'h5555_AAAA;
        issue(ALUOP_MULTU, 32'd2, 32'd3);
        bus.wr_lo_i = 1'b0;
        chk("mtlo_start", 64'(bus.lo_o), 64'd42);
        wait_done(n);
        chk("mtlo_start_res", 64'(bus.lo_o), 64'd6);

        issue(ALUOP_DIV, 32'hFFFF_FF9C, 32'd7);
        repeat (19) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_hi", 64'(bus.hi_o), 64'd0);
        chk("abort_lo", 64'(bus.lo_o), 64'd0);
        wait_done(n);
        chk("abort_nodone", 64'(n), 64'd40);
        run("after_rst", ALUOP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        for (int i = 0; i < 50000; i++) begin
            bit legal;
            bus.start_i = $urandom_range(0, 3) == 0;
            legal       = $urandom_range(0, 9) < 8;
            bus.aluop_i = legal ? codes[$urandom_range(0, 3)] : 5'($urandom_range(0, 3));
            bus.src0_i  = pick_val();
            bus.src1_i  = pick_val();
            bus.wdata_i = $urandom;
            bus.wr_hi_i = !(bus.start_i && !legal) && $urandom_range(0, 9) == 0;
            bus.wr_lo_i = !(bus.start_i && !legal) && $urandom_range(0, 9) == 0;
            tick();
        end
        bus.start_i = 1'b0;
        bus.wr_hi_i = 1'b0;
        bus.wr_lo_i = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
